// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by a word-addressed memory with a fixed number of wait states.
// Unsupported sizes, misaligned or out-of-range addresses get a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] addr_q;
  logic          wr_q, err_q;
  logic [31:0]   mem [MEM_DEPTH];
  logic          open, accept, bad;
  logic          unused_htrans0;

  // A new address phase can only be taken while the current data phase is completing.
  assign open   = (state == IDLE) | (state == DATA) | (state == ERR2);
  assign accept = open & HSEL & HREADYIN & HTRANS[1];
  assign bad    = (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00) | (HADDR[31:AW+2] != '0);
  assign unused_htrans0 = HTRANS[0];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = DATA;
      end
      ERR1:    state_nx = ERR2;
      default: state_nx = IDLE;
    endcase
    if (accept) begin
      if (bad) state_nx = ERR1;
      else if (WAIT_STATES > 0) begin
        state_nx = WAIT;
        cnt_nx   = 4'(WAIT_STATES);
      end else state_nx = DATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q <= HADDR[AW+1:2];
        wr_q   <= HWRITE;
        err_q  <= bad;
      end
    end
  end

  // Memory has no reset; a write still pending when reset hits is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == DATA && wr_q && !err_q) mem[addr_q] <= HWDATA;
  end

  always_comb begin
    HREADYOUT = !((state == WAIT) || (state == ERR1));
    HRESP     = ((state == ERR1) || (state == ERR2)) ? 2'b01 : 2'b00;
    HRDATA    = (state == DATA && !wr_q) ? mem[addr_q] : 32'h0;
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: three slaves (0, 2, 3 wait states) share one bus; the driver queues
// expected responses on accept and a negedge monitor checks each completed data phase.
module tb_ahb_sram_slave;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        hready;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  int          cur;

  logic [31:0] rd [3];
  logic        ro [3];
  logic [1:0]  rs [3];
  logic [2:0]  sel;

  always #5 HCLK = ~HCLK;

  assign sel[0] = hsel && (cur == 0);
  assign sel[1] = hsel && (cur == 1);
  assign sel[2] = hsel && (cur == 2);

  always_comb begin
    hready = ro[cur];
    hrdata = rd[cur];
    hresp  = rs[cur];
  end

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(hready),
    .HRDATA(rd[0]), .HREADYOUT(ro[0]), .HRESP(rs[0]));
  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(hready),
    .HRDATA(rd[1]), .HREADYOUT(ro[1]), .HRESP(rs[1]));
  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[2]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(hready),
    .HRDATA(rd[2]), .HREADYOUT(ro[2]), .HRESP(rs[2]));

  typedef struct {
    logic [31:0] addr;
    bit          write;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          seq;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_waits;
  } beat_t;

  typedef struct {
    bit          write;
    bit          err;
    int          waits;
    logic [31:0] data;
  } exp_t;

  beat_t seq_q[$];
  exp_t  scb[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] addr, input bit write, input logic [2:0] size,
                     input logic [31:0] wdata, input bit seq, input logic [31:0] exp_data,
                     input bit exp_err, input int exp_waits);
    beat_t b;
    b.addr = addr; b.write = write; b.size = size; b.wdata = wdata; b.seq = seq;
    b.exp_data = exp_data; b.exp_err = exp_err; b.exp_waits = exp_waits;
    seq_q.push_back(b);
  endtask

  task automatic bus_idle();
    hsel = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'b010;
  endtask

  // Pipelined master: drives queued beats back-to-back, holding each address phase until ready.
  task automatic run();
    int    i = 0;
    int    cyc = 0;
    bit    have_d = 0;
    bit    rdy;
    beat_t d;
    exp_t  e;
    while ((i < seq_q.size() || have_d) && cyc < 200) begin
      if (i < seq_q.size()) begin
        hsel = 1'b1; HADDR = seq_q[i].addr; HTRANS = seq_q[i].seq ? 2'b11 : 2'b10;
        HWRITE = seq_q[i].write; HSIZE = seq_q[i].size;
      end else bus_idle();
      HWDATA = have_d ? d.wdata : 32'h0;
      @(negedge HCLK);
      rdy = hready;
      @(posedge HCLK); #1;
      cyc++;
      if (rdy) begin
        have_d = 0;
        if (i < seq_q.size()) begin
          d = seq_q[i];
          e.write = d.write; e.err = d.exp_err; e.waits = d.exp_waits; e.data = d.exp_data;
          scb.push_back(e);
          have_d = 1;
          i++;
        end
      end
    end
    if (cyc >= 200) begin
      total++; bad++;
      $display("FAIL run_timeout actual=%0d cycles required<200", cyc);
    end
    bus_idle();
    HWDATA = 32'h0;
    seq_q.delete();
  endtask

  task automatic pulse_reset();
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
  endtask

  // Monitor: tracks each data phase from accept to completion and scores it.
  initial begin
    bit         active = 0;
    int         stalls = 0;
    logic [1:0] stall_resp = 2'b00;
    exp_t       e;
    forever begin
      @(negedge HCLK);
      if (HRESET) active = 0;
      else begin
        if (active) begin
          if (!hready) begin
            stalls++;
            stall_resp = hresp;
          end else begin
            active = 0;
            if (scb.size() == 0) chk("unexpected_response", 32'd1, 32'd0);
            else begin
              e = scb.pop_front();
              chk("resp", 32'(hresp), e.err ? 32'd1 : 32'd0);
              chk("wait_cycles", 32'(stalls), 32'(e.waits));
              if (stalls > 0) chk("stall_resp", 32'(stall_resp), e.err ? 32'd1 : 32'd0);
              if (!e.write && !e.err) chk("rdata", hrdata, e.data);
            end
          end
        end
        if (hready && hsel && HTRANS[1]) begin
          active = 1; stalls = 0; stall_resp = 2'b00;
        end
      end
    end
  end

  initial begin
    cur = 0; HRESET = 1'b1; HWDATA = 32'h0;
    bus_idle();
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cur = k; #1;
      chk("reset_hready", 32'(hready), 32'd1);
      chk("reset_hresp", 32'(hresp), 32'd0);
      chk("reset_hrdata", hrdata, 32'h0);
    end
    cur = 0;
    @(posedge HCLK); #1;

    // Zero wait states: preload, then write followed immediately by a read of the same word.
    add(32'h20, 1, 3'b010, 32'h1111_1111, 0, 32'h0, 0, 0);
    add(32'h10, 1, 3'b010, 32'hDEAD_BEEF, 0, 32'h0, 0, 0);
    add(32'h10, 0, 3'b010, 32'h0, 0, 32'hDEAD_BEEF, 0, 0);
    run();

    // Memory survives reset.
    pulse_reset();
    chk("post_reset_hready", 32'(hready), 32'd1);
    add(32'h20, 0, 3'b010, 32'h0, 0, 32'h1111_1111, 0, 0);
    run();

    // Two wait states: burst write 1..4, then 4-beat INCR burst read.
    cur = 1;
    add(32'h0, 1, 3'b010, 32'd1, 0, 32'h0, 0, 2);
    add(32'h4, 1, 3'b010, 32'd2, 1, 32'h0, 0, 2);
    add(32'h8, 1, 3'b010, 32'd3, 1, 32'h0, 0, 2);
    add(32'hC, 1, 3'b010, 32'd4, 1, 32'h0, 0, 2);
    run();
    add(32'h0, 0, 3'b010, 32'h0, 0, 32'd1, 0, 2);
    add(32'h4, 0, 3'b010, 32'h0, 1, 32'd2, 0, 2);
    add(32'h8, 0, 3'b010, 32'h0, 1, 32'd3, 0, 2);
    add(32'hC, 0, 3'b010, 32'h0, 1, 32'd4, 0, 2);
    run();

    // Out-of-range read, then the bus returns to OKAY.
    cur = 0;
    add(32'h400, 0, 3'b010, 32'h0, 0, 32'h0, 1, 1);
    run();
    chk("after_err_hready", 32'(hready), 32'd1);
    chk("after_err_hresp", 32'(hresp), 32'd0);
    chk("after_err_hrdata", hrdata, 32'h0);

    // Byte-size write errors and leaves mem[1] alone; a chained read follows ERR2.
    add(32'h4, 1, 3'b010, 32'hCAFE_0001, 0, 32'h0, 0, 0);
    add(32'h4, 1, 3'b000, 32'hFFFF_FFFF, 0, 32'h0, 1, 1);
    add(32'h4, 0, 3'b010, 32'h0, 0, 32'hCAFE_0001, 0, 0);
    add(32'h6, 0, 3'b010, 32'h0, 0, 32'h0, 1, 1);
    run();

    // Three wait states: reset during the second wait cycle discards the write.
    cur = 2;
    add(32'h8, 1, 3'b010, 32'hA5A5_0002, 0, 32'h0, 0, 3);
    run();
    hsel = 1'b1; HADDR = 32'h8; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = 32'h0BAD_0BAD;
    chk("abort_wait1_hready", 32'(hready), 32'd0);
    @(posedge HCLK); #1;
    chk("abort_wait2_hready", 32'(hready), 32'd0);
    pulse_reset();
    HWDATA = 32'h0;
    chk("abort_hready", 32'(hready), 32'd1);
    chk("abort_hresp", 32'(hresp), 32'd0);
    repeat (4) @(posedge HCLK);
    #1;
    add(32'h8, 0, 3'b010, 32'h0, 0, 32'hA5A5_0002, 0, 3);
    run();

    repeat (3) @(posedge HCLK);
    #1;
    chk("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
